// File: rtl/multdiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_ctrl_pkg
//
// Shared types and constants for the multiply/divide sequencing controller.
//   md_state_e : controller states (IDLE, LOAD, RUN, FIX, DONE)
//   md_op_e    : operation kind latched on a start pulse
//   MD_MULT_CYCLES / MD_DIV_CYCLES : default iteration counts
//   decode_op()  : start-pulse priority (multiply beats divide)
// -----------------------------------------------------------------------------
package multdiv_ctrl_pkg;

  // Iteration steps for a radix-4 Booth 32-bit multiply and a restoring
  // 32-bit divide.
  localparam int MD_MULT_CYCLES = 16;
  localparam int MD_DIV_CYCLES  = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } md_state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } md_op_e;

  // When both start pulses arrive together the multiply wins.
  function automatic md_op_e decode_op(input logic mult, input logic div);
    return (div && !mult) ? OP_DIV : OP_MULT;
  endfunction

endpackage

// File: rtl/multdiv_ctrl_counter.sv
// -----------------------------------------------------------------------------
// multdiv_ctrl_counter
//
// CNT_W-bit iteration up-counter for the multdiv controller. State updates on
// the falling clock edge, matching the rest of the controller.
//
// Ports:
//   clk   in  : clock (falling edge active)
//   clr   in  : asynchronous active-high clear
//   sclr  in  : synchronous clear (has priority over en)
//   en    in  : count enable
//   count out : current count
// -----------------------------------------------------------------------------
module multdiv_ctrl_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sclr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (sclr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// multdiv_ctrl
//
// Sequencing controller for the multi-cycle multiply/divide datapath. A start
// pulse (ctrl_MULT / ctrl_DIV) in any state aborts whatever is running and
// walks the datapath through LOAD -> RUN (N iterations) -> FIX -> DONE.
// A divide whose divisor was zero at the start edge skips RUN/FIX and reports
// an exception straight from LOAD. All state changes on the falling edge.
//
// Build option:
//   MULTDIV_EARLY_TERM_EN : when defined, a multiply in RUN ends early (moves
//                           to FIX with count frozen) when mult_rem_zero is
//                           high at an edge. When undefined mult_rem_zero is
//                           ignored and latency is fixed.
//
// Parameters:
//   MULT_CYCLES : multiply iteration steps
//   DIV_CYCLES  : divide iteration steps
//   CNT_W       : counter width, 2**CNT_W > max(MULT_CYCLES, DIV_CYCLES)
//
// Ports:
//   clk            in  : clock (falling edge active)
//   clr            in  : asynchronous active-high reset
//   ctrl_MULT      in  : multiply start pulse
//   ctrl_DIV       in  : divide start pulse
//   divisor_zero   in  : divisor is zero, sampled on the start edge
//   mult_overflow  in  : product overflow, sampled on the FIX edge
//   mult_rem_zero  in  : remaining multiplier bits zero (early-term build only)
//   load           out : datapath loads operands (LOAD)
//   step_en        out : datapath iterates (RUN)
//   fix_en         out : datapath sign-fix / final select (FIX)
//   op_is_div      out : latched operation is a divide
//   count          out : iterations completed
//   stall          out : pipeline hold (LOAD, RUN, FIX)
//   data_resultRDY out : result valid (DONE, one cycle)
//   data_exception out : exception, meaningful only with data_resultRDY
// -----------------------------------------------------------------------------
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             divisor_zero,
  input  logic             mult_overflow,
  input  logic             mult_rem_zero,
  output logic             load,
  output logic             step_en,
  output logic             fix_en,
  output logic             op_is_div,
  output logic [CNT_W-1:0] count,
  output logic             stall,
  output logic             data_resultRDY,
  output logic             data_exception
);

  // Count value present at the edge that ends the final iteration.
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state;
  md_state_e        state_nxt;
  md_op_e           op_q;
  logic             exc_q;

  logic             start;
  md_op_e           start_op;
  logic [CNT_W-1:0] last_cnt;
  logic             last_step;
  logic             early_term;
  logic             cnt_en;

  // ---------------------------------------------------------------------------
  // Start decode and iteration bookkeeping
  // ---------------------------------------------------------------------------
  assign start     = ctrl_MULT | ctrl_DIV;
  assign start_op  = decode_op(ctrl_MULT, ctrl_DIV);
  assign last_cnt  = (op_q == OP_DIV) ? DIV_LAST : MULT_LAST;
  assign last_step = (count == last_cnt);

`ifdef MULTDIV_EARLY_TERM_EN
  // Once the remaining multiplier bits are zero further Booth steps add
  // nothing, so the multiply can go straight to FIX.
  assign early_term = (state == RUN) && (op_q == OP_MULT) && mult_rem_zero;
`else
  logic unused_rem_zero;
  assign unused_rem_zero = mult_rem_zero;
  assign early_term      = 1'b0;
`endif

  // The counter advances on every RUN edge, including the last one, so it
  // reads N through FIX and DONE. An early-terminated multiply freezes it.
  assign cnt_en = (state == RUN) && !early_term;

  multdiv_ctrl_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .clr   (clr),
    .sclr  (start),
    .en    (cnt_en),
    .count (count)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Operation and exception flags. divisor_zero only matters for a divide, so
  // the exception flag is latched as "divide by zero" on the start edge and
  // overwritten with the overflow flag on a multiply's FIX edge.
  // ---------------------------------------------------------------------------
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      op_q  <= OP_MULT;
      exc_q <= 1'b0;
    end else if (start) begin
      op_q  <= start_op;
      exc_q <= (start_op == OP_DIV) && divisor_zero;
    end else if ((state == FIX) && (op_q == OP_MULT)) begin
      exc_q <= mult_overflow;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    load           = 1'b0;
    step_en        = 1'b0;
    fix_en         = 1'b0;
    stall          = 1'b0;
    data_resultRDY = 1'b0;
    data_exception = 1'b0;

    unique case (state)
      IDLE: begin
        state_nxt = IDLE;
      end
      LOAD: begin
        load  = 1'b1;
        stall = 1'b1;
        // Divide by zero has nothing to iterate on: report immediately.
        state_nxt = ((op_q == OP_DIV) && exc_q) ? DONE : RUN;
      end
      RUN: begin
        step_en = 1'b1;
        stall   = 1'b1;
        if (early_term || last_step) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        fix_en    = 1'b1;
        stall     = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        data_resultRDY = 1'b1;
        data_exception = exc_q;
        state_nxt      = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A new start aborts anything in flight, from any state.
    if (start) begin
      state_nxt = LOAD;
    end
  end

  assign op_is_div = (op_q == OP_DIV);

endmodule
